// File: rtl/readout_rx_pkg.sv
// readout_rx_pkg
// Shared definitions for the readout receive path: the trial-controller FSM
// state encoding and the offset-binary bin-count midpoint helper.
// No ports (package).
package readout_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_FINISH = 2'd2
    } rx_state_e;

    // Offset-binary zero point of a bin counter of the given width: 2^(width-1).
    // Returned wide so each user can slice it down to its own counter width.
    function automatic logic [63:0] bin_midpoint(input int unsigned width);
        return 64'd1 << (width - 1);
    endfunction

endpackage

// File: rtl/readout_rx_bin_counter.sv
// readout_rx_bin_counter
// Saturating up/down counter holding the offset-binary bin count. A load
// returns it to the midpoint; an enabled step moves it by one toward all-ones
// (up_i=1) or toward zero (up_i=0) and sticks at either end instead of wrapping.
// Ports:
//   clk      - clock
//   rst      - synchronous active-low reset (count goes to midpoint)
//   load_i   - load midpoint (takes priority over a step)
//   en_i     - apply one step this cycle
//   up_i     - step direction, 1 = increment, 0 = decrement
//   count_o  - registered count
module readout_rx_bin_counter
    import readout_rx_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_i,
    input  logic             en_i,
    input  logic             up_i,
    output logic [WIDTH-1:0] count_o
);

    localparam logic [63:0]      MID64 = bin_midpoint(WIDTH);
    localparam logic [WIDTH-1:0] MID   = MID64[WIDTH-1:0];

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = MID;
        end else if (en_i) begin
            if (up_i && (count_q != '1)) begin
                count_d = count_q + WIDTH'(1);
            end else if (!up_i && (count_q != '0)) begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            count_q <= MID;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/readout_rx_trial_controller.sv
// readout_rx_trial_controller
// Sequences a multi-trial readout measurement. Each trial accumulates a fixed
// number of classified samples into a cumulative offset-binary bin count, then
// spends one FINISH cycle presenting the count and threshold address to the
// external state-decision block. The decision block either ends the
// measurement (decision_fin_in) or lets the next trial begin; the final trial
// always ends it.
// Ports:
//   clk, rst                 - clock, synchronous active-low reset
//   start_in                 - one-cycle start request (honoured in IDLE only)
//   trial_length_in          - samples per trial (0 behaves as 1), latched at start
//   max_trial_in             - trial count (0 behaves as 1), latched at start
//   base_threshold_addr_in   - threshold entry for trial 0, latched at start
//   sample_valid_in          - classified sample present
//   sample_state_in          - sample class, 1 = |1>, 0 = |0>
//   decision_fin_in          - decision-complete flag, looked at in FINISH only
//   bin_count_out            - registered cumulative bin count
//   finish_trial_out         - high during the FINISH cycle
//   last_trial_out           - high during FINISH of the final trial
//   threshold_addr_out       - registered threshold entry for the current trial
//   busy_out                 - high while not IDLE
//   done_out                 - registered one-cycle completion pulse
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | waiting for start_in; samples and decision flag ignored
// ST_ACCUM  | counting valid samples of the current trial into the bin count
// ST_FINISH | one-cycle trial boundary; decision block samples the outputs
module readout_rx_trial_controller
    import readout_rx_pkg::*;
#(
    parameter int unsigned BIN_COUNTER_WIDTH           = 16,
    parameter int unsigned THRESHOLD_MEMORY_ADDR_WIDTH = 4,
    parameter int unsigned TRIAL_LENGTH_WIDTH          = 8,
    parameter int unsigned MAX_TRIAL_WIDTH             = 4
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start_in,
    input  logic [TRIAL_LENGTH_WIDTH-1:0]          trial_length_in,
    input  logic [MAX_TRIAL_WIDTH-1:0]             max_trial_in,
    input  logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] base_threshold_addr_in,
    input  logic                                   sample_valid_in,
    input  logic                                   sample_state_in,
    input  logic                                   decision_fin_in,
    output logic [BIN_COUNTER_WIDTH-1:0]           bin_count_out,
    output logic                                   finish_trial_out,
    output logic                                   last_trial_out,
    output logic [THRESHOLD_MEMORY_ADDR_WIDTH-1:0] threshold_addr_out,
    output logic                                   busy_out,
    output logic                                   done_out
);

    localparam int unsigned TLW = TRIAL_LENGTH_WIDTH;
    localparam int unsigned MTW = MAX_TRIAL_WIDTH;
    localparam int unsigned AW  = THRESHOLD_MEMORY_ADDR_WIDTH;

    rx_state_e      state_q;
    logic [TLW-1:0] trial_len_q;
    // Holds max_trial-1 so the final-trial test is a plain equality.
    logic [MTW-1:0] max_trial_m1_q;
    logic [MTW-1:0] trial_idx_q;
    logic [TLW-1:0] sample_cnt_q;
    logic [AW-1:0]  thr_addr_q;
    logic           done_q;

    logic [TLW-1:0] sample_cnt_inc;
    logic           last_trial_w;
    logic           start_w;
    logic           count_en_w;

    assign sample_cnt_inc = sample_cnt_q + TLW'(1);
    assign last_trial_w   = (trial_idx_q == max_trial_m1_q);
    assign start_w        = (state_q == ST_IDLE) && start_in;
    assign count_en_w     = (state_q == ST_ACCUM) && sample_valid_in;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= ST_IDLE;
            trial_len_q    <= '0;
            max_trial_m1_q <= '0;
            trial_idx_q    <= '0;
            sample_cnt_q   <= '0;
            thr_addr_q     <= '0;
            done_q         <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start_in) begin
                        trial_len_q    <= (trial_length_in == '0) ? TLW'(1) : trial_length_in;
                        max_trial_m1_q <= (max_trial_in == '0) ? '0 : (max_trial_in - MTW'(1));
                        trial_idx_q    <= '0;
                        sample_cnt_q   <= '0;
                        thr_addr_q     <= base_threshold_addr_in;
                        state_q        <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (sample_valid_in) begin
                        sample_cnt_q <= sample_cnt_inc;
                        if (sample_cnt_inc == trial_len_q) begin
                            state_q <= ST_FINISH;
                        end
                    end
                end
                ST_FINISH: begin
                    // Final trial ends the measurement even without a decision.
                    if (decision_fin_in || last_trial_w) begin
                        done_q  <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        trial_idx_q  <= trial_idx_q + MTW'(1);
                        thr_addr_q   <= thr_addr_q + AW'(1);
                        sample_cnt_q <= '0;
                        state_q      <= ST_ACCUM;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    readout_rx_bin_counter #(
        .WIDTH (BIN_COUNTER_WIDTH)
    ) u_bin_counter (
        .clk     (clk),
        .rst     (rst),
        .load_i  (start_w),
        .en_i    (count_en_w),
        .up_i    (sample_state_in),
        .count_o (bin_count_out)
    );

    assign finish_trial_out   = (state_q == ST_FINISH);
    assign last_trial_out     = (state_q == ST_FINISH) && last_trial_w;
    assign busy_out           = (state_q != ST_IDLE);
    assign threshold_addr_out = thr_addr_q;
    assign done_out           = done_q;

endmodule

// File: tb/tb_readout_rx_trial_controller.sv
// tb_readout_rx_trial_controller
// Directed bench for readout_rx_trial_controller: a 16-bit-count instance for
// the sequencing scenarios and a 4-bit-count instance for saturation.
module tb_readout_rx_trial_controller;

    logic       clk;
    logic       rst;
    logic       start_in;
    logic       start4;
    logic [7:0] trial_length;
    logic [3:0] max_trial;
    logic [3:0] base_addr;
    logic       sample_valid;
    logic       sample_state;
    logic       decision_fin;

    logic [15:0] bin;
    logic        finish, last, busy, done;
    logic [3:0]  thr;

    logic [3:0]  bin4;
    logic        finish4, last4, busy4, done4;
    logic [3:0]  thr4;

    int vectors    = 0;
    int miscompares = 0;

    readout_rx_trial_controller dut (
        .clk                    (clk),
        .rst                    (rst),
        .start_in               (start_in),
        .trial_length_in        (trial_length),
        .max_trial_in           (max_trial),
        .base_threshold_addr_in (base_addr),
        .sample_valid_in        (sample_valid),
        .sample_state_in        (sample_state),
        .decision_fin_in        (decision_fin),
        .bin_count_out          (bin),
        .finish_trial_out       (finish),
        .last_trial_out         (last),
        .threshold_addr_out     (thr),
        .busy_out               (busy),
        .done_out               (done)
    );

    readout_rx_trial_controller #(
        .BIN_COUNTER_WIDTH (4)
    ) dut4 (
        .clk                    (clk),
        .rst                    (rst),
        .start_in               (start4),
        .trial_length_in        (trial_length),
        .max_trial_in           (max_trial),
        .base_threshold_addr_in (base_addr),
        .sample_valid_in        (sample_valid),
        .sample_state_in        (sample_state),
        .decision_fin_in        (decision_fin),
        .bin_count_out          (bin4),
        .finish_trial_out       (finish4),
        .last_trial_out         (last4),
        .threshold_addr_out     (thr4),
        .busy_out               (busy4),
        .done_out               (done4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // mode 0: all |0>, 1: all |1>, 2: alternating starting with |1>
    task automatic feed(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            sample_valid = 1'b1;
            if (mode == 2) sample_state = (i % 2 == 0);
            else           sample_state = (mode == 1);
            tick();
        end
        sample_valid = 1'b0;
        sample_state = 1'b0;
    endtask

    initial begin
        rst          = 1'b0;
        start_in     = 1'b0;
        start4       = 1'b0;
        trial_length = 8'd4;
        max_trial    = 4'd3;
        base_addr    = 4'd2;
        sample_valid = 1'b0;
        sample_state = 1'b0;
        decision_fin = 1'b0;
        tick();
        tick();

        // Reset state
        check("rst_busy",   busy,   0);
        check("rst_bin",    bin,    32768);
        check("rst_thr",    thr,    0);
        check("rst_done",   done,   0);
        check("rst_finish", finish, 0);
        check("rst_last",   last,   0);
        check("rst_bin4",   bin4,   8);
        rst = 1'b1;
        tick();

        // Four |1> samples, decision at first FINISH
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("s1_busy", busy, 1);
        check("s1_thr",  thr,  2);
        check("s1_bin0", bin,  32768);
        feed(4, 1);
        check("s1_finish", finish, 1);
        check("s1_bin",    bin,    32772);
        check("s1_thr_f",  thr,    2);
        check("s1_last",   last,   0);
        check("s1_done_f", done,   0);
        decision_fin = 1'b1;
        tick();
        decision_fin = 1'b0;
        check("s1_done",     done,   1);
        check("s1_idle",     busy,   0);
        check("s1_finish_0", finish, 0);
        tick();
        check("s1_done_end", done, 0);

        // Three trials, no decision, alternating samples; decision flag held high
        // during ACCUM must be ignored there
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        decision_fin = 1'b1;
        feed(4, 2);
        decision_fin = 1'b0;
        check("s2_t0_finish", finish, 1);
        check("s2_t0_thr",    thr,    2);
        check("s2_t0_last",   last,   0);
        check("s2_t0_bin",    bin,    32768);
        tick();
        check("s2_t1_accum", finish, 0);
        check("s2_t1_thr",   thr,    3);
        decision_fin = 1'b1;
        feed(4, 2);
        decision_fin = 1'b0;
        check("s2_t1_finish", finish, 1);
        check("s2_t1_thr_f",  thr,    3);
        check("s2_t1_last",   last,   0);
        tick();
        check("s2_t2_thr", thr, 4);
        feed(4, 2);
        check("s2_t2_finish", finish, 1);
        check("s2_t2_thr_f",  thr,    4);
        check("s2_t2_last",   last,   1);
        check("s2_t2_bin",    bin,    32768);
        tick();
        check("s2_done", done, 1);
        check("s2_idle", busy, 0);
        tick();
        check("s2_done_end", done, 0);

        // 4-bit count saturation at both ends
        trial_length = 8'd20;
        max_trial    = 4'd1;
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("s3_bin_start", bin4, 8);
        feed(10, 1);
        check("s3_bin_mid_hi", bin4,    15);
        check("s3_not_fin",    finish4, 0);
        feed(10, 1);
        check("s3_finish_hi", finish4, 1);
        check("s3_last_hi",   last4,   1);
        check("s3_sat_hi",    bin4,    15);
        check("s3_dut16_idle", busy,   0);
        decision_fin = 1'b1;
        tick();
        decision_fin = 1'b0;
        check("s3_done_hi", done4, 1);
        start4 = 1'b1;
        tick();
        start4 = 1'b0;
        check("s3_reload", bin4, 8);
        feed(20, 0);
        check("s3_finish_lo", finish4, 1);
        check("s3_sat_lo",    bin4,    0);
        decision_fin = 1'b1;
        tick();
        decision_fin = 1'b0;
        check("s3_done_lo", done4, 1);
        tick();

        // Start during ACCUM ignored; samples during FINISH ignored
        trial_length = 8'd4;
        max_trial    = 4'd3;
        base_addr    = 4'd2;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        feed(2, 1);
        check("s4_bin2", bin, 32770);
        start_in     = 1'b1;
        sample_valid = 1'b1;
        sample_state = 1'b1;
        tick();
        start_in     = 1'b0;
        sample_valid = 1'b0;
        check("s4_no_restart_bin", bin,  32771);
        check("s4_no_restart_thr", thr,  2);
        check("s4_busy",           busy, 1);
        feed(1, 1);
        check("s4_finish", finish, 1);
        check("s4_bin_f",  bin,    32772);
        sample_valid = 1'b1;
        sample_state = 1'b1;
        tick();
        sample_valid = 1'b0;
        sample_state = 1'b0;
        check("s4_fin_sample_ignored", bin, 32772);
        check("s4_thr_t1",             thr, 3);
        check("s4_accum",              finish, 0);

        // Reset during trial 2 abandons the measurement
        feed(4, 1);
        check("s5_t1_finish", finish, 1);
        check("s5_t1_bin",    bin,    32776);
        tick();
        check("s5_t2_thr", thr, 4);
        feed(2, 1);
        check("s5_t2_bin", bin, 32778);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check("s5_rst_busy",   busy,   0);
        check("s5_rst_bin",    bin,    32768);
        check("s5_rst_thr",    thr,    0);
        check("s5_rst_done",   done,   0);
        check("s5_rst_finish", finish, 0);
        tick();
        check("s5_no_done", done, 0);
        check("s5_idle",    busy, 0);

        // Zero settings behave as one sample, one trial; missing decision on the
        // final trial still completes
        trial_length = 8'd0;
        max_trial    = 4'd0;
        base_addr    = 4'd5;
        start_in = 1'b1;
        tick();
        start_in = 1'b0;
        check("s6_thr", thr, 5);
        feed(1, 0);
        check("s6_finish", finish, 1);
        check("s6_last",   last,   1);
        check("s6_bin",    bin,    32767);
        tick();
        check("s6_done", done, 1);
        check("s6_idle", busy, 0);
        tick();
        check("s6_done_end", done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
